// File: rtl/execute_stage.sv
// MIPS32 execute stage: B-operand mux, instruction decode into an ALU
// operation, ALU result/Zero, branch target, destination register select,
// and the 64-bit HI/LO accumulator used by mult/multu/madd/msub.
module execute_stage (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] ReadData1,
    input  logic [31:0] ReadData2,
    input  logic [4:0]  Instruction_10_6,
    input  logic [31:0] Instruction_15_0_Extended,
    input  logic [4:0]  Instruction_20_16,
    input  logic [4:0]  Instruction_15_11,
    input  logic [31:0] PCAddResult,
    input  logic        ALUSrc,
    input  logic [31:0] InstructionToALU,
    input  logic        RegDst,
    input  logic        HiLoWrite,
    input  logic        Madd,
    input  logic        Msub,
    output logic [31:0] ReadDataHi,
    output logic [31:0] ReadDataLo,
    output logic [31:0] PCAddResultOut,
    output logic [31:0] ALUResult,
    output logic        Zero,
    output logic [4:0]  WriteRegister
);

    // Major opcodes
    localparam logic [5:0] OP_SPECIAL  = 6'b000000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_BNE      = 6'b000101;
    localparam logic [5:0] OP_ADDI     = 6'b001000;
    localparam logic [5:0] OP_ADDIU    = 6'b001001;
    localparam logic [5:0] OP_SLTI     = 6'b001010;
    localparam logic [5:0] OP_SLTIU    = 6'b001011;
    localparam logic [5:0] OP_ANDI     = 6'b001100;
    localparam logic [5:0] OP_ORI      = 6'b001101;
    localparam logic [5:0] OP_XORI     = 6'b001110;
    localparam logic [5:0] OP_LUI      = 6'b001111;
    localparam logic [5:0] OP_LB       = 6'b100000;
    localparam logic [5:0] OP_LH       = 6'b100001;
    localparam logic [5:0] OP_LW       = 6'b100011;
    localparam logic [5:0] OP_SB       = 6'b101000;
    localparam logic [5:0] OP_SH       = 6'b101001;
    localparam logic [5:0] OP_SW       = 6'b101011;

    // SPECIAL function codes
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    // SPECIAL2 function code
    localparam logic [5:0] F_MUL   = 6'b000010;

    typedef enum logic [4:0] {
        ALU_ZERO, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV,
        ALU_SRAV, ALU_MFHI, ALU_MFLO, ALU_LUI, ALU_MUL
    } alu_op_e;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    alu_op_e     alu_op;
    logic        imm_zext;
    logic [31:0] imm;
    logic [31:0] a_operand;
    logic [31:0] b_operand;
    logic [63:0] hilo_q;
    logic [63:0] hilo_d;
    logic [63:0] prod_signed;
    logic [63:0] prod_unsigned;
    logic        unused_instr_bits;

    assign opcode = InstructionToALU[31:26];
    assign funct  = InstructionToALU[5:0];
    // Register fields of the instruction word are routed in separately.
    assign unused_instr_bits = ^InstructionToALU[25:6];

    // Decode the instruction word into an ALU operation and immediate style.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        alu_op   = ALU_ZERO;
        imm_zext = 1'b0;
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    F_ADD, F_ADDU: alu_op = ALU_ADD;
                    F_SUB, F_SUBU: alu_op = ALU_SUB;
                    F_AND:         alu_op = ALU_AND;
                    F_OR:          alu_op = ALU_OR;
                    F_XOR:         alu_op = ALU_XOR;
                    F_NOR:         alu_op = ALU_NOR;
                    F_SLT:         alu_op = ALU_SLT;
                    F_SLTU:        alu_op = ALU_SLTU;
                    F_SLL:         alu_op = ALU_SLL;
                    F_SRL:         alu_op = ALU_SRL;
                    F_SRA:         alu_op = ALU_SRA;
                    F_SLLV:        alu_op = ALU_SLLV;
                    F_SRLV:        alu_op = ALU_SRLV;
                    F_SRAV:        alu_op = ALU_SRAV;
                    F_MFHI:        alu_op = ALU_MFHI;
                    F_MFLO:        alu_op = ALU_MFLO;
                    default:       alu_op = ALU_ZERO; // mult/multu and undecoded
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW,
            OP_LB, OP_SB, OP_LH, OP_SH:         alu_op = ALU_ADD;
            OP_ANDI: begin alu_op = ALU_AND; imm_zext = 1'b1; end
            OP_ORI:  begin alu_op = ALU_OR;  imm_zext = 1'b1; end
            OP_XORI: begin alu_op = ALU_XOR; imm_zext = 1'b1; end
            OP_SLTI:                            alu_op = ALU_SLT;
            OP_SLTIU:                           alu_op = ALU_SLTU;
            OP_LUI:                             alu_op = ALU_LUI;
            OP_BEQ, OP_BNE:                     alu_op = ALU_SUB;
            OP_SPECIAL2: begin
                // madd/msub only touch HI/LO; their ALU result stays zero.
                if (funct == F_MUL) alu_op = ALU_MUL;
            end
            default:                            alu_op = ALU_ZERO;
        endcase
    end

    // Logical immediates are zero-extended; everything else uses the sign-extended form.
    assign imm       = imm_zext ? {16'b0, Instruction_15_0_Extended[15:0]}
                                : Instruction_15_0_Extended;
    assign a_operand = ReadData1;
    assign b_operand = ALUSrc ? imm : ReadData2;

    // ALU datapath: same-cycle result selected by the decoded operation.
    always_comb begin
        ALUResult = 32'd0;
        case (alu_op)
            ALU_ADD:  ALUResult = a_operand + b_operand;
            ALU_SUB:  ALUResult = a_operand - b_operand;
            ALU_AND:  ALUResult = a_operand & b_operand;
            ALU_OR:   ALUResult = a_operand | b_operand;
            ALU_XOR:  ALUResult = a_operand ^ b_operand;
            ALU_NOR:  ALUResult = ~(a_operand | b_operand);
            ALU_SLT:  ALUResult = {31'd0, $signed(a_operand) < $signed(b_operand)};
            ALU_SLTU: ALUResult = {31'd0, a_operand < b_operand};
            ALU_SLL:  ALUResult = b_operand << Instruction_10_6;
            ALU_SRL:  ALUResult = b_operand >> Instruction_10_6;
            ALU_SRA:  ALUResult = $signed(b_operand) >>> Instruction_10_6;
            ALU_SLLV: ALUResult = b_operand << ReadData1[4:0];
            ALU_SRLV: ALUResult = b_operand >> ReadData1[4:0];
            ALU_SRAV: ALUResult = $signed(b_operand) >>> ReadData1[4:0];
            ALU_MFHI: ALUResult = hilo_q[63:32];
            ALU_MFLO: ALUResult = hilo_q[31:0];
            ALU_LUI:  ALUResult = {Instruction_15_0_Extended[15:0], 16'd0};
            // The low 32 bits of a product are the same for signed and unsigned operands.
            ALU_MUL:  ALUResult = a_operand * b_operand;
            default:  ALUResult = 32'd0;
        endcase
    end

    assign Zero           = (ALUResult == 32'd0);
    assign PCAddResultOut = PCAddResult + (Instruction_15_0_Extended << 2);
    assign WriteRegister  = RegDst ? Instruction_15_11 : Instruction_20_16;

    // Full 64-bit products of rs and rt for the HI/LO accumulator.
    assign prod_signed   = {{32{ReadData1[31]}}, ReadData1} * {{32{ReadData2[31]}}, ReadData2};
    assign prod_unsigned = {32'd0, ReadData1} * {32'd0, ReadData2};

    // HI/LO next state in priority order: conflict hold, madd, msub, product write.
    always_comb begin
        hilo_d = hilo_q;
        if (Madd && Msub) begin
            hilo_d = hilo_q;
        end else if (Madd) begin
            hilo_d = hilo_q + prod_signed;
        end else if (Msub) begin
            hilo_d = hilo_q - prod_signed;
        end else if (HiLoWrite) begin
            hilo_d = (funct == F_MULTU) ? prod_unsigned : prod_signed;
        end
    end

    // HI/LO register, cleared asynchronously by Reset.
    always_ff @(posedge Clk or posedge Reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (Reset) hilo_q <= 64'd0;
        else       hilo_q <= hilo_d;
    end

    assign ReadDataHi = hilo_q[63:32];
    assign ReadDataLo = hilo_q[31:0];

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: scoreboard of expected ALU and
// HI/LO results, plus direct checks of branch target and register select.
module tb_execute_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] ReadData1, ReadData2;
    logic [4:0]  Instruction_10_6;
    logic [31:0] Instruction_15_0_Extended;
    logic [4:0]  Instruction_20_16, Instruction_15_11;
    logic [31:0] PCAddResult;
    logic        ALUSrc;
    logic [31:0] InstructionToALU;
    logic        RegDst, HiLoWrite, Madd, Msub;
    logic [31:0] ReadDataHi, ReadDataLo, PCAddResultOut, ALUResult;
    logic        Zero;
    logic [4:0]  WriteRegister;

    execute_stage dut (
        .Clk(Clk), .Reset(Reset),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .Instruction_10_6(Instruction_10_6),
        .Instruction_15_0_Extended(Instruction_15_0_Extended),
        .Instruction_20_16(Instruction_20_16),
        .Instruction_15_11(Instruction_15_11),
        .PCAddResult(PCAddResult), .ALUSrc(ALUSrc),
        .InstructionToALU(InstructionToALU), .RegDst(RegDst),
        .HiLoWrite(HiLoWrite), .Madd(Madd), .Msub(Msub),
        .ReadDataHi(ReadDataHi), .ReadDataLo(ReadDataLo),
        .PCAddResultOut(PCAddResultOut), .ALUResult(ALUResult),
        .Zero(Zero), .WriteRegister(WriteRegister)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t        sb[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [63:0] hilo_m;     // reference HI/LO value

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] r_type(input logic [5:0] fn);
        return {26'd0, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [5:0] fn);
        return {op, 20'd0, fn};
    endfunction

    // Independent reference for the SPECIAL register ops used in random tests.
    function automatic logic [31:0] model_r(input logic [5:0] fn, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        int sa, sb_i;
        sa = a; sb_i = b;
        case (fn)
            6'b100001: return a + b;
            6'b100011: return a - b;
            6'b100100: return a & b;
            6'b100101: return a | b;
            6'b100110: return a ^ b;
            6'b100111: return ~(a | b);
            6'b101010: return (sa < sb_i) ? 32'd1 : 32'd0;
            6'b101011: return (a < b) ? 32'd1 : 32'd0;
            6'b000000: return b << sh;
            6'b000010: return b >> sh;
            6'b000011: return 32'(sb_i >>> sh);
            6'b000100: return b << a[4:0];
            default:   return 32'd0;
        endcase
    endfunction

    task automatic idle_ctrl();
        Madd = 1'b0; Msub = 1'b0; HiLoWrite = 1'b0;
    endtask

    // Drive one ALU operation, queue its expected result, and compare after settling.
    task automatic run_alu(input string tag, input logic [31:0] instr, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [31:0] imm_ext, input logic alusrc,
                           input logic [4:0] shamt, input logic [31:0] exp);
        exp_t it;
        @(negedge Clk);
        idle_ctrl();
        InstructionToALU = instr; ReadData1 = rs; ReadData2 = rt;
        Instruction_15_0_Extended = imm_ext; ALUSrc = alusrc; Instruction_10_6 = shamt;
        sb.push_back('{tag, {32'd0, exp}});
        #1;
        it = sb.pop_front();
        check(it.tag, {32'd0, ALUResult}, it.val);
        check({it.tag, "_zero"}, {63'd0, Zero}, {63'd0, it.val == 64'd0});
    endtask

    // Drive HI/LO controls for one edge; checks no early change, then the post-edge value.
    task automatic run_hilo(input string tag, input logic madd, input logic msub, input logic hlw,
                            input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                            input logic [63:0] exp);
        exp_t it;
        @(negedge Clk);
        Madd = madd; Msub = msub; HiLoWrite = hlw;
        InstructionToALU = instr; ReadData1 = rs; ReadData2 = rt; ALUSrc = 1'b0;
        sb.push_back('{tag, exp});
        #1;
        check({tag, "_pre"}, {ReadDataHi, ReadDataLo}, hilo_m);
        @(posedge Clk);
        #1;
        it = sb.pop_front();
        check(it.tag, {ReadDataHi, ReadDataLo}, it.val);
        hilo_m = exp;
        idle_ctrl();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  fn_tab [12];
        logic [63:0] p;
        logic [31:0] a, b;
        logic [4:0]  sh;
        logic [5:0]  fn;

        fn_tab = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                   6'b101010, 6'b101011, 6'b000000, 6'b000010, 6'b000011, 6'b000100};

        Reset = 1'b1; idle_ctrl();
        ReadData1 = '0; ReadData2 = '0; Instruction_10_6 = '0;
        Instruction_15_0_Extended = '0; Instruction_20_16 = '0; Instruction_15_11 = '0;
        PCAddResult = '0; ALUSrc = 1'b0; InstructionToALU = '0; RegDst = 1'b0;
        hilo_m = 64'd0;
        #12;
        check("reset_hilo", {ReadDataHi, ReadDataLo}, 64'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // Directed ALU vectors
        run_alu("add",      r_type(6'b100000), 32'd5, 32'd7, 32'd0, 1'b0, 5'd0, 32'd12);
        run_alu("sub_zero", r_type(6'b100010), 32'd7, 32'd7, 32'd0, 1'b0, 5'd0, 32'd0);
        run_alu("addi",     i_type(6'b001000, 6'd0), 32'd5, 32'd0, 32'd9, 1'b1, 5'd0, 32'd14);
        run_alu("slt",      r_type(6'b101010), 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd0, 32'd1);
        run_alu("sltu",     r_type(6'b101011), 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd0, 32'd0);
        run_alu("andi_zx",  i_type(6'b001100, 6'd0), 32'hFFFF_FFFF, 32'd0, 32'hFFFF_8001, 1'b1, 5'd0, 32'h0000_8001);
        run_alu("ori_zx",   i_type(6'b001101, 6'd0), 32'h1200_0000, 32'd0, 32'hFFFF_8000, 1'b1, 5'd0, 32'h1200_8000);
        run_alu("slti",     i_type(6'b001010, 6'd0), 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'd1);
        run_alu("lui",      i_type(6'b001111, 6'd0), 32'd0, 32'd0, 32'hFFFF_1234, 1'b1, 5'd0, 32'h1234_0000);
        run_alu("lw",       i_type(6'b100011, 6'd0), 32'h1000, 32'd0, 32'hFFFF_FFFC, 1'b1, 5'd0, 32'h0FFC);
        run_alu("sra",      r_type(6'b000011), 32'd0, 32'h8000_0000, 32'd0, 1'b0, 5'd4, 32'hF800_0000);
        run_alu("srlv",     r_type(6'b000110), 32'h24, 32'h8000_0000, 32'd0, 1'b0, 5'd0, 32'h0800_0000);
        run_alu("srav",     r_type(6'b000111), 32'h3F, 32'h8000_0000, 32'd0, 1'b0, 5'd0, 32'hFFFF_FFFF);
        run_alu("nor",      r_type(6'b100111), 32'h0F0F_0000, 32'h0000_F0F0, 32'd0, 1'b0, 5'd0, 32'hF0F0_0F0F);
        run_alu("beq",      i_type(6'b000100, 6'd0), 32'd9, 32'd9, 32'd3, 1'b0, 5'd0, 32'd0);
        run_alu("bne",      i_type(6'b000101, 6'd0), 32'd9, 32'd4, 32'd3, 1'b0, 5'd0, 32'd5);
        run_alu("mul",      i_type(6'b011100, 6'b000010), 32'hFFFF_FFFD, 32'd7, 32'd0, 1'b0, 5'd0, 32'hFFFF_FFEB);
        run_alu("madd_alu", i_type(6'b011100, 6'b000000), 32'd3, 32'd4, 32'd0, 1'b0, 5'd0, 32'd0);
        run_alu("mult_alu", r_type(6'b011000), 32'd3, 32'd4, 32'd0, 1'b0, 5'd0, 32'd0);
        run_alu("undecoded", i_type(6'b111111, 6'd0), 32'd3, 32'd4, 32'd0, 1'b0, 5'd0, 32'd0);

        // Randomised register ops against the reference model
        for (int i = 0; i < 24; i++) begin
            fn = fn_tab[$urandom_range(0, 11)];
            a  = $urandom(); b = $urandom(); sh = 5'($urandom_range(0, 31));
            run_alu($sformatf("rand%0d_fn%0h", i, fn), r_type(fn), a, b, 32'd0, 1'b0, sh,
                    model_r(fn, a, b, sh));
        end

        // Branch target and destination register select
        @(negedge Clk);
        PCAddResult = 32'd1; Instruction_15_0_Extended = 32'd6;
        RegDst = 1'b0; Instruction_20_16 = 5'd15; Instruction_15_11 = 5'd8;
        #1;
        check("pc_target_fwd", {32'd0, PCAddResultOut}, 64'h19);
        check("wreg_rt", {59'd0, WriteRegister}, 64'd15);
        RegDst = 1'b1; PCAddResult = 32'd8; Instruction_15_0_Extended = 32'hFFFF_FFFF;
        #1;
        check("pc_target_back", {32'd0, PCAddResultOut}, 64'd4);
        check("wreg_rd", {59'd0, WriteRegister}, 64'd8);

        // HI/LO accumulator: spec vectors, starting from reset
        run_hilo("madd1", 1'b1, 1'b0, 1'b0, i_type(6'b011100, 6'b000000),
                 32'd2000000020, 32'd4, 64'h0000_0001_DCD6_5050);
        run_hilo("msub1", 1'b0, 1'b1, 1'b0, i_type(6'b011100, 6'b000100),
                 32'd2000000040, 32'd6, 64'hFFFF_FFFF_1194_D760);
        run_alu("mfhi", r_type(6'b010000), 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'hFFFF_FFFF);
        run_alu("mflo", r_type(6'b010010), 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'h1194_D760);
        run_hilo("both_hold", 1'b1, 1'b1, 1'b1, r_type(6'b011000), 32'd9, 32'd9, hilo_m);
        run_hilo("idle_hold", 1'b0, 1'b0, 1'b0, r_type(6'b011000), 32'd9, 32'd9, hilo_m);
        run_hilo("mult",  1'b0, 1'b0, 1'b1, r_type(6'b011000), 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
        run_hilo("multu", 1'b0, 1'b0, 1'b1, r_type(6'b011001), 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA);
        run_hilo("madd_over_write", 1'b1, 1'b0, 1'b1, r_type(6'b011001), 32'd2, 32'd3,
                 64'h0000_0003_0000_0000);

        // Madd held for three edges accumulates three times
        @(negedge Clk);
        Madd = 1'b1; ReadData1 = 32'd3; ReadData2 = 32'hFFFF_FFFB;   // 3 * -5
        for (int k = 1; k <= 3; k++) sb.push_back('{$sformatf("madd_hold%0d", k), hilo_m - 64'(15 * k)});
        for (int k = 0; k < 3; k++) begin
            exp_t it;
            @(posedge Clk);
            #1;
            it = sb.pop_front();
            check(it.tag, {ReadDataHi, ReadDataLo}, it.val);
        end
        hilo_m = hilo_m - 64'd45;
        idle_ctrl();

        // Randomised madd/msub against a 64-bit reference
        for (int i = 0; i < 8; i++) begin
            logic dosub;
            a = $urandom(); b = $urandom(); dosub = 1'($urandom_range(0, 1));
            p = 64'(longint'($signed(a)) * longint'($signed(b)));
            run_hilo($sformatf("rand_acc%0d", i), !dosub, dosub, 1'b0,
                     i_type(6'b011100, 6'd0), a, b, dosub ? hilo_m - p : hilo_m + p);
        end

        // Asynchronous reset mid-accumulate, away from any clock edge
        @(negedge Clk);
        Madd = 1'b1; ReadData1 = 32'd1000; ReadData2 = 32'd1000;
        #2;
        Reset = 1'b1;
        #1;
        check("async_reset", {ReadDataHi, ReadDataLo}, 64'd0);
        @(posedge Clk);
        #1;
        check("reset_dominates", {ReadDataHi, ReadDataLo}, 64'd0);
        @(negedge Clk);
        Reset = 1'b0; idle_ctrl();
        hilo_m = 64'd0;
        run_hilo("madd_after_reset", 1'b1, 1'b0, 1'b0, i_type(6'b011100, 6'd0),
                 32'd1000, 32'd1000, 64'd1000000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
